melody_player: RTL

MELODY_PLAYER -- requirements
Module: melody_player

---
 rtl/melody_pkg.sv | 23 ++
 rtl/tone_gen.sv | 56 +++++
 rtl/melody_player.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/melody_pkg.sv
// Shared types and constants for the melody player: FSM state encoding and the
// pitch-to-half-period table (half-periods in 50 MHz clock cycles).
package melody_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StTone,
    StGap,
    StPause
  } state_e;

  typedef logic [16:0] half_per_t;

  // 0 is a rest; 1..7 = M1..M7, 8..15 = H1..H7 and C7
  localparam half_per_t HALF_PER [0:15] = '{
    17'd0,     17'd47800, 17'd42575, 17'd37925,
    17'd35793, 17'd31875, 17'd28400, 17'd25300,
    17'd23875, 17'd21283, 17'd18961, 17'd17897,
    17'd15944, 17'd14205, 17'd12655, 17'd11945
  };

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: counts through one full period of 2*half_per cycles.
// Duty is fixed at 50% (low half first) unless MELODY_PLAYER_VOL_EN adds vol_i.
module tone_gen
  import melody_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  half_per_t half_per_i,
  input  logic      en_i,
  input  logic      clr_i,
`ifdef MELODY_PLAYER_VOL_EN
  input  logic [1:0] vol_i,
`endif
  output logic      tone_o
);

  logic [17:0] per_q, per_d;
  logic [17:0] per_len;
  logic        rest;

  assign per_len = {half_per_i, 1'b0};
  assign rest    = (half_per_i == '0);

  always_comb begin
    per_d = per_q;
    if (clr_i) begin
      per_d = '0;
    end else if (en_i && !rest) begin
      if (per_q == per_len - 18'd1) begin
        per_d = '0;
      end else begin
        per_d = per_q + 18'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      per_q <= '0;
    end else begin
      per_q <= per_d;
    end
  end

  always_comb begin
    tone_o = 1'b0;
    if (en_i && !rest) begin
`ifdef MELODY_PLAYER_VOL_EN
      tone_o = (per_q < (per_len >> ({1'b0, vol_i} + 3'd1)));
`else
      tone_o = (per_q >= {1'b0, half_per_i});
`endif
    end
  end

endmodule

// File: rtl/melody_player.sv
// Score-RAM driven melody player: fetches {pitch, dur} entries and plays each as
// a tone followed by a short gap. Optional MELODY_PLAYER_VOL_EN adds a vol input.
module melody_player
  import melody_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned BEAT_CYC = 12_500_000,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [5:0]    wr_data,
  input  logic [AW:0]   len,
  input  logic          start,
  input  logic          play,
  input  logic          loop,
`ifdef MELODY_PLAYER_VOL_EN
  input  logic [1:0]    vol,
`endif
  output logic          tone_out,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] note_idx
);

  // Wide enough for the longest note, 4 beats
  localparam int unsigned CW = $clog2(4 * BEAT_CYC + 1);

  state_e        state_q, state_d;
  state_e        ret_q, ret_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic          done_q, done_d;

  logic [5:0]    mem_q [DEPTH];
  logic [5:0]    entry_q;

  logic [CW-1:0] note_len, gap_len, tone_len;
  logic          last_note;
  state_e        end_state;
  logic [AW-1:0] end_idx;
  logic          end_done;
  logic          tone_en, tone_clr;

  // Score RAM: no reset; a same-cycle write/read returns the old entry
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (state_q == StFetch) begin
      entry_q <= mem_q[idx_q];
    end
  end

  always_comb begin
    case (entry_q[1:0])
      2'd0:    note_len = CW'(BEAT_CYC);
      2'd1:    note_len = CW'(2 * BEAT_CYC);
      2'd2:    note_len = CW'(3 * BEAT_CYC);
      default: note_len = CW'(4 * BEAT_CYC);
    endcase
    gap_len  = note_len >> 3;
    tone_len = note_len - gap_len;
  end

  // Where to go once the current note (tone + gap) has finished
  always_comb begin
    last_note = (({1'b0, idx_q} + (AW+1)'(1)) >= len_q);
    end_state = StFetch;
    end_idx   = idx_q + AW'(1);
    end_done  = 1'b0;
    if (last_note) begin
      if (loop) begin
        end_idx = '0;
      end else begin
        end_state = StIdle;
        end_idx   = idx_q;
        end_done  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ret_q   <= StTone;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    done_d  = 1'b0;
    if (start) begin
      len_d   = len;
      idx_d   = '0;
      cnt_d   = '0;
      state_d = (len != '0) ? StFetch : StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StFetch: begin
          if (play) begin
            state_d = StTone;
            cnt_d   = '0;
          end
        end
        StTone: begin
          if (!play) begin
            state_d = StPause;
            ret_d   = StTone;
          end else if (cnt_q == tone_len - CW'(1)) begin
            cnt_d = '0;
            if (gap_len == '0) begin
              state_d = end_state;
              idx_d   = end_idx;
              done_d  = end_done;
            end else begin
              state_d = StGap;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        StGap: begin
          if (!play) begin
            state_d = StPause;
            ret_d   = StGap;
          end else if (cnt_q == gap_len - CW'(1)) begin
            cnt_d   = '0;
            state_d = end_state;
            idx_d   = end_idx;
            done_d  = end_done;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        StPause: begin
          if (play) begin
            state_d = ret_q;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    busy     = (state_q != StIdle);
    tone_en  = (state_q == StTone) && play;
    tone_clr = (state_q == StIdle) || (state_q == StFetch);
  end

  assign done     = done_q;
  assign note_idx = idx_q;

  tone_gen u_tone_gen (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .half_per_i (HALF_PER[entry_q[5:2]]),
    .en_i       (tone_en),
    .clr_i      (tone_clr),
`ifdef MELODY_PLAYER_VOL_EN
    .vol_i      (vol),
`endif
    .tone_o     (tone_out)
  );

endmodule
